// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: opcodes, FSM states,
// flag bit positions and the reserved-opcode predicate.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_EOR  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_RSB  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_RSC  = 4'b0111;
  localparam logic [3:0] OP_MOVA = 4'b1000;
  localparam logic [3:0] OP_SUB4 = 4'b1010;
  localparam logic [3:0] OP_ORR  = 4'b1100;
  localparam logic [3:0] OP_MOVB = 4'b1101;
  localparam logic [3:0] OP_BIC  = 4'b1110;
  localparam logic [3:0] OP_MVN  = 4'b1111;

  localparam logic [3:0] OP_RSV9 = 4'b1001;
  localparam logic [3:0] OP_RSVB = 4'b1011;

  // Flag register bit positions: {N, Z, C, V}
  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSV9) || (op == OP_RSVB);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_nzcv_reg.sv
// Architectural NZCV flag register. An ALU commit and a direct MSR write may
// land on the same edge; the ALU commit takes priority.
module nzcv_reg #(
  parameter logic [3:0] NZCV_RST = 4'b0000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       alu_we_i,
  input  logic [3:0] alu_nzcv_i,
  input  logic       msr_we_i,
  input  logic [3:0] msr_nzcv_i,
  output logic [3:0] nzcv_o
);

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;

  // Next flag value: ALU commit over MSR write over hold
  always_comb begin
    nzcv_d = nzcv_q;
    if (alu_we_i) begin
      nzcv_d = alu_nzcv_i;
    end else if (msr_we_i) begin
      nzcv_d = msr_nzcv_i;
    end
  end

  // Flag storage with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nzcv_q <= NZCV_RST;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign nzcv_o = nzcv_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencing controller for the shared combinational ALU: accepts a request,
// holds the operands for SETTLE cycles, captures F/NZCV, returns the result
// and optionally commits the flags into the architectural register.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter logic [3:0]  NZCV_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_s,
  input  logic        req_shc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_f,
  output logic [3:0]  res_nzcv,
  output logic        res_err,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cf,
  output logic        alu_vf,
  output logic        alu_shc,
  input  logic [31:0] alu_f,
  input  logic [3:0]  alu_nzcv,
  input  logic        msr_we,
  input  logic [3:0]  msr_nzcv,
  output logic [3:0]  nzcv
);

  state_e      state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [3:0]  alu_op_q,   alu_op_d;
  logic [31:0] alu_a_q,    alu_a_d;
  logic [31:0] alu_b_q,    alu_b_d;
  logic        alu_cf_q,   alu_cf_d;
  logic        alu_vf_q,   alu_vf_d;
  logic        alu_shc_q,  alu_shc_d;
  logic        s_q,        s_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_f_q,    res_f_d;
  logic [3:0]  res_nzcv_q, res_nzcv_d;
  logic        res_err_q,  res_err_d;
  logic        commit;
  logic        rsv;

  // Next-state, datapath latches and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cf_d    = alu_cf_q;
    alu_vf_d    = alu_vf_q;
    alu_shc_d   = alu_shc_q;
    s_d         = s_q;
    res_valid_d = res_valid_q;
    res_f_d     = res_f_q;
    res_nzcv_d  = res_nzcv_q;
    res_err_d   = res_err_q;
    req_ready   = 1'b0;
    commit      = 1'b0;
    rsv         = is_reserved(alu_op_q);
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          alu_op_d  = req_op;
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          s_d       = req_s;
          alu_shc_d = req_shc;
          // Carry/overflow inputs come from the committed flags at accept
          alu_cf_d  = nzcv[NZCV_C];
          alu_vf_d  = nzcv[NZCV_V];
          cnt_d     = 4'(SETTLE - 1);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_f_d     = rsv ? '0 : alu_f;
          res_nzcv_d  = rsv ? '0 : alu_nzcv;
          res_err_d   = rsv;
          res_valid_d = 1'b1;
          commit      = s_q && !rsv;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cf_q    <= 1'b0;
      alu_vf_q    <= 1'b0;
      alu_shc_q   <= 1'b0;
      s_q         <= 1'b0;
      res_valid_q <= 1'b0;
      res_f_q     <= '0;
      res_nzcv_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cf_q    <= alu_cf_d;
      alu_vf_q    <= alu_vf_d;
      alu_shc_q   <= alu_shc_d;
      s_q         <= s_d;
      res_valid_q <= res_valid_d;
      res_f_q     <= res_f_d;
      res_nzcv_q  <= res_nzcv_d;
      res_err_q   <= res_err_d;
    end
  end

  nzcv_reg #(
    .NZCV_RST (NZCV_RST)
  ) u_nzcv_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .alu_we_i   (commit),
    .alu_nzcv_i (alu_nzcv),
    .msr_we_i   (msr_we),
    .msr_nzcv_i (msr_nzcv),
    .nzcv_o     (nzcv)
  );

  assign res_valid = res_valid_q;
  assign res_f     = res_f_q;
  assign res_nzcv  = res_nzcv_q;
  assign res_err   = res_err_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cf    = alu_cf_q;
  assign alu_vf    = alu_vf_q;
  assign alu_shc   = alu_shc_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a behavioural ALU closes the loop, a table of
// operations is run through a scoreboard queue, then reset/MSR corner cases.
module tb_alu_exec_ctrl;

  localparam int unsigned SETTLE = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_s;
  logic        req_shc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_f;
  logic [3:0]  res_nzcv;
  logic        res_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cf;
  logic        alu_vf;
  logic        alu_shc;
  logic [31:0] alu_f;
  logic [3:0]  alu_nzcv;
  logic        msr_we;
  logic [3:0]  msr_nzcv;
  logic [3:0]  nzcv;
  logic [35:0] alu_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_exec_ctrl #(
    .SETTLE   (SETTLE),
    .NZCV_RST (4'b0000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_shc(req_shc),
    .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
    .res_nzcv(res_nzcv), .res_err(res_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cf(alu_cf),
    .alu_vf(alu_vf), .alu_shc(alu_shc), .alu_f(alu_f), .alu_nzcv(alu_nzcv),
    .msr_we(msr_we), .msr_nzcv(msr_nzcv), .nzcv(nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; reserved codes return a non-zero pattern on purpose
  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cf,
                                            input logic vf, input logic shc);
    logic [32:0] sum;
    logic [31:0] x, y, f;
    logic        cin, c, v, arith;
    arith = 1'b1; x = a; y = b; cin = 1'b0;
    case (op)
      4'b0010, 4'b1010: begin y = ~b; cin = 1'b1; end
      4'b0011: begin x = b; y = ~a; cin = 1'b1; end
      4'b0100: ;
      4'b0101: cin = cf;
      4'b0110: begin y = ~b; cin = cf; end
      4'b0111: begin x = b; y = ~a; cin = cf; end
      default: arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + 33'(cin);
    if (arith) begin
      f = sum[31:0];
      c = sum[32];
      v = (x[31] == y[31]) && (f[31] != x[31]);
    end else begin
      case (op)
        4'b0000: f = a & b;
        4'b0001: f = a ^ b;
        4'b1000: f = a;
        4'b1100: f = a | b;
        4'b1101: f = b;
        4'b1110: f = a & ~b;
        4'b1111: f = ~b;
        default: f = 32'hdeadbeef;
      endcase
      c = shc;
      v = vf;
    end
    return {f[31], (f == 32'd0), c, v, f};
  endfunction

  assign alu_out  = alu_model(alu_op, alu_a, alu_b, alu_cf, alu_vf, alu_shc);
  assign alu_f    = alu_out[31:0];
  assign alu_nzcv = alu_out[35:32];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        shc;
    logic        msr_en;
    logic [3:0]  msr_val;
    int unsigned hold;
    logic [31:0] exp_f;
    logic [3:0]  exp_rnzcv;
    logic        exp_err;
    logic        exp_cf;
    logic        exp_vf;
    logic [3:0]  exp_arch;
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entry and exit: 1 time unit after a rising edge, controller idle
  task automatic run_op(input vec_t v);
    vec_t        e;
    int unsigned n;
    logic [31:0] f_hold;
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
    req_s = v.s; req_shc = v.shc;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb_q.push_back(v);
    chk("req_ready_exec", 64'(req_ready), 64'd0);
    chk("alu_op", 64'(alu_op), 64'(v.op));
    chk("alu_cf_accept", 64'(alu_cf), 64'(v.exp_cf));
    chk("alu_vf_accept", 64'(alu_vf), 64'(v.exp_vf));
    n = 0;
    while (1) begin
      if (v.msr_en && n == SETTLE - 1) begin
        msr_we = 1'b1; msr_nzcv = v.msr_val;
      end
      @(posedge clk); #1;
      msr_we = 1'b0;
      n++;
      if (res_valid || n > 20) break;
    end
    chk("latency", 64'(n), 64'(SETTLE));
    chk("alu_cf_held", 64'(alu_cf), 64'(v.exp_cf));
    chk("alu_vf_held", 64'(alu_vf), 64'(v.exp_vf));
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk("res_f", 64'(res_f), 64'(e.exp_f));
      chk("res_nzcv", 64'(res_nzcv), 64'(e.exp_rnzcv));
      chk("res_err", 64'(res_err), 64'(e.exp_err));
      chk("nzcv_arch", 64'(nzcv), 64'(e.exp_arch));
    end
    f_hold = res_f;
    for (int unsigned h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("stall_res_valid", 64'(res_valid), 64'd1);
      chk("stall_res_f", 64'(res_f), 64'(f_hold));
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_drop", 64'(res_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //          op       a             b             s  shc msr  mval   hold f             rnzcv  err cf vf arch
    vecs[0]  = '{4'b0100, 32'hac963a55, 32'h365aacf9, 1, 0, 0, 4'b0000, 0, 32'he2f0e74e, 4'b1000, 0, 0, 0, 4'b1000};
    vecs[1]  = '{4'b0010, 32'hac963a55, 32'h365aacf9, 1, 0, 0, 4'b0000, 0, 32'h763b8d5c, 4'b0011, 0, 0, 0, 4'b0011};
    vecs[2]  = '{4'b0101, 32'hac963a55, 32'h365aacf9, 0, 0, 0, 4'b0000, 0, 32'he2f0e74f, 4'b1000, 0, 1, 1, 4'b0011};
    vecs[3]  = '{4'b0000, 32'hac963a55, 32'h365aacf9, 0, 0, 1, 4'b0100, 0, 32'h24122851, 4'b0001, 0, 1, 1, 4'b0100};
    vecs[4]  = '{4'b1101, 32'h12345678, 32'h00000000, 1, 1, 0, 4'b0000, 0, 32'h00000000, 4'b0110, 0, 0, 0, 4'b0110};
    vecs[5]  = '{4'b1111, 32'h12345678, 32'h00000000, 1, 0, 0, 4'b0000, 0, 32'hffffffff, 4'b1000, 0, 1, 0, 4'b1000};
    vecs[6]  = '{4'b0001, 32'hffff0000, 32'h0ff00ff0, 0, 0, 0, 4'b0000, 0, 32'hf00f0ff0, 4'b1000, 0, 0, 0, 4'b1000};
    vecs[7]  = '{4'b0011, 32'h00000001, 32'h00000000, 1, 0, 0, 4'b0000, 0, 32'hffffffff, 4'b1000, 0, 0, 0, 4'b1000};
    vecs[8]  = '{4'b1011, 32'hac963a55, 32'h365aacf9, 1, 0, 0, 4'b0000, 5, 32'h00000000, 4'b0000, 1, 0, 0, 4'b1000};
    vecs[9]  = '{4'b1001, 32'h00000001, 32'h00000001, 1, 1, 0, 4'b0000, 0, 32'h00000000, 4'b0000, 1, 0, 0, 4'b1000};
    vecs[10] = '{4'b0100, 32'h7fffffff, 32'h00000001, 1, 0, 0, 4'b0000, 0, 32'h80000000, 4'b1001, 0, 0, 0, 4'b1001};
    vecs[11] = '{4'b0110, 32'h00000005, 32'h00000005, 1, 0, 0, 4'b0000, 0, 32'hffffffff, 4'b1000, 0, 0, 1, 4'b1000};
    vecs[12] = '{4'b0100, 32'hffffffff, 32'h00000001, 1, 0, 1, 4'b0001, 0, 32'h00000000, 4'b0110, 0, 0, 0, 4'b0110};
    vecs[13] = '{4'b0101, 32'h00000000, 32'h00000000, 1, 0, 0, 4'b0000, 0, 32'h00000001, 4'b0000, 0, 1, 0, 4'b0000};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_s = 1'b0; req_shc = 1'b0; res_ready = 1'b0; msr_we = 1'b0; msr_nzcv = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_nzcv", 64'(nzcv), 64'd0);
    chk("rst_alu_bus", {alu_a, alu_b}, 64'd0);
    chk("rst_alu_ctl", 64'({alu_op, alu_cf, alu_vf, alu_shc}), 64'd0);
    chk("rst_res", 64'({res_f, res_nzcv, res_err}), 64'd0);

    for (int unsigned i = 0; i < 14; i++) begin
      run_op(vecs[i]);
    end

    // Reset while an op is in EXEC: nothing commits, no result appears
    req_valid = 1'b1; req_op = 4'b0100; req_a = 32'h7fffffff; req_b = 32'h00000001;
    req_s = 1'b1; req_shc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_exec", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_nzcv", 64'(nzcv), 64'd0);
    chk("abort_alu_a", 64'(alu_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_after_valid", 64'(res_valid), 64'd0);
    chk("abort_after_nzcv", 64'(nzcv), 64'd0);

    // Direct flag write while idle
    msr_we = 1'b1; msr_nzcv = 4'b1010;
    @(posedge clk); #1;
    msr_we = 1'b0;
    chk("msr_idle", 64'(nzcv), 64'(4'b1010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
